// File: rtl/tdm_demux_pair.sv
// Two-bank TDM demultiplexer: stages words into banks A/B, then publishes both at once.
// Optional pair counter enabled by defining TDM_DEMUX_PAIRCNT_EN; otherwise pair_cnt reads 0.
module tdm_demux_pair #(
   parameter int N = 4
) (
   input  logic         CLOCK_50,
   input  logic         reset,
   input  logic [N-1:0] d,
   input  logic         s,
   input  logic         valid,
   input  logic         auto_mode,
   output logic         ready,
   output logic [N-1:0] qa,
   output logic [N-1:0] qb,
   output logic         pair_done,
   output logic [7:0]   pair_cnt,
   output logic [9:4]   LEDR
);

   // state   | meaning
   // COLLECT | accepting words into staging banks A/B
   // DONE    | both banks staged; publish to qa/qb on the next edge
   typedef enum logic {
      COLLECT = 1'b0,
      DONE    = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   ra_q, ra_d;
   logic [N-1:0]   rb_q, rb_d;
   logic [N-1:0]   qa_q, qa_d;
   logic [N-1:0]   qb_q, qb_d;
   logic           flag_a_q, flag_a_d;
   logic           flag_b_q, flag_b_d;
   logic           pair_done_q, pair_done_d;
   logic           accept;
   logic           to_b;

   assign ready  = (state_q == COLLECT);
   assign accept = valid & ready;
   // In auto mode the destination follows the current A flag, so a mode
   // switch mid-collection simply picks up from whatever is already staged.
   assign to_b   = auto_mode ? flag_a_q : s;

   always_comb begin
      state_d     = state_q;
      ra_d        = ra_q;
      rb_d        = rb_q;
      qa_d        = qa_q;
      qb_d        = qb_q;
      flag_a_d    = flag_a_q;
      flag_b_d    = flag_b_q;
      pair_done_d = 1'b0;
      case (state_q)
         COLLECT: begin
            if (accept) begin
               if (to_b) begin
                  rb_d     = d;
                  flag_b_d = 1'b1;
               end else begin
                  ra_d     = d;
                  flag_a_d = 1'b1;
               end
            end
            if (flag_a_d && flag_b_d) state_d = DONE;
         end
         DONE: begin
            qa_d        = ra_q;
            qb_d        = rb_q;
            flag_a_d    = 1'b0;
            flag_b_d    = 1'b0;
            pair_done_d = 1'b1;
            state_d     = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= COLLECT;
         ra_q        <= '0;
         rb_q        <= '0;
         qa_q        <= '0;
         qb_q        <= '0;
         flag_a_q    <= 1'b0;
         flag_b_q    <= 1'b0;
         pair_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ra_q        <= ra_d;
         rb_q        <= rb_d;
         qa_q        <= qa_d;
         qb_q        <= qb_d;
         flag_a_q    <= flag_a_d;
         flag_b_q    <= flag_b_d;
         pair_done_q <= pair_done_d;
      end
   end

`ifdef TDM_DEMUX_PAIRCNT_EN
   logic [7:0] pair_cnt_q, pair_cnt_d;

   always_comb begin
      pair_cnt_d = pair_cnt_q;
      if (state_q == DONE) pair_cnt_d = pair_cnt_q + 8'd1;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) pair_cnt_q <= 8'd0;
      else       pair_cnt_q <= pair_cnt_d;
   end

   assign pair_cnt = pair_cnt_q;
`else
   assign pair_cnt = 8'd0;
`endif

   assign qa        = qa_q;
   assign qb        = qb_q;
   assign pair_done = pair_done_q;
   assign LEDR      = {flag_a_q, flag_b_q, (state_q == DONE), 3'b000};

endmodule
